// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencing stage.
// Imported by the alignment checker and the controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  localparam logic [1:0] EXC_LD_MIS  = 2'd0;
  localparam logic [1:0] EXC_ST_MIS  = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT = 2'd2;
  localparam logic [1:0] EXC_ILLEGAL = 2'd3;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // fn3 3/6/7 never name a load or store; stores have no unsigned form
  function automatic logic fn3_illegal(
    input logic [2:0] fn3,
    input logic       we
  );
    logic bad;
    bad = (fn3 == 3'd3) || (fn3 == 3'd6) || (fn3 == 3'd7);
    return bad || (we && fn3[2]);
  endfunction

endpackage

// File: rtl/lsu_align_chk.sv
// Combinational legality and alignment check of an incoming memory op.
// Illegal encodings take priority over misalignment.
module lsu_align_chk
  import lsu_pkg::*;
(
  input  logic [2:0] fn3_i,
  input  logic       we_i,
  input  logic [1:0] addr_low_i,
  output logic       ok_o,
  output logic [1:0] cause_o
);

  logic mis;

  // Size-dependent alignment, then fold in the illegal-fn3 case
  always_comb begin
    mis = 1'b0;
    case (fn3_i[1:0])
      SZ_H:    mis = addr_low_i[0];
      SZ_W:    mis = (addr_low_i != 2'b00);
      default: mis = 1'b0;
    endcase
    ok_o    = 1'b1;
    cause_o = EXC_LD_MIS;
    if (fn3_illegal(fn3_i, we_i)) begin
      ok_o    = 1'b0;
      cause_o = EXC_ILLEGAL;
    end else if (mis) begin
      ok_o    = 1'b0;
      cause_o = we_i ? EXC_ST_MIS : EXC_LD_MIS;
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one op, runs a single word bus access,
// then reports writeback or an exception for one cycle.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_fn3,
  input  logic [31:0] req_addr,
  input  logic [4:0]  req_rd,
  output logic [2:0]  adj_fn3,
  output logic [1:0]  adj_addr_low,
  input  logic [31:0] adj_wdata,
  input  logic [3:0]  adj_mask,
  input  logic [31:0] adj_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_mask,
  input  logic        bus_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        exc_valid,
  output logic [1:0]  exc_cause
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  fn3_q, fn3_d;
  logic [31:0] addr_q, addr_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic        exc_q, exc_d;
  logic [1:0]  cause_q, cause_d;
  logic [TW-1:0] timer_q, timer_d;

  logic       chk_ok;
  logic [1:0] chk_cause;

  lsu_align_chk u_chk (
    .fn3_i      (req_fn3),
    .we_i       (req_we),
    .addr_low_i (req_addr[1:0]),
    .ok_o       (chk_ok),
    .cause_o    (chk_cause)
  );

  // Next-state: accept, bus wait with timeout, one-cycle response
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    fn3_d   = fn3_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    data_d  = data_q;
    exc_d   = exc_q;
    cause_d = cause_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          fn3_d   = req_fn3;
          addr_d  = req_addr;
          rd_d    = req_rd;
          timer_d = '0;
          exc_d   = !chk_ok;
          if (!chk_ok) cause_d = chk_cause;
          state_d = chk_ok ? BUS : RESP;
        end
      end
      BUS: begin
        if (bus_ack) begin
          state_d = RESP;
          exc_d   = 1'b0;
          if (!we_q) data_d = adj_rdata;
        end else if (timer_q == T_LAST) begin
          state_d = RESP;
          exc_d   = 1'b1;
          cause_d = EXC_TIMEOUT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched-op registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      fn3_q   <= '0;
      addr_q  <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      exc_q   <= 1'b0;
      cause_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      fn3_q   <= fn3_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
      cause_q <= cause_d;
      timer_q <= timer_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign adj_fn3      = fn3_q;
  assign adj_addr_low = addr_q[1:0];

  assign bus_req   = (state_q == BUS);
  assign bus_we    = bus_req && we_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_wdata = bus_req ? adj_wdata : 32'h0;
  assign bus_mask  = we_q ? adj_mask : 4'b1111;

  assign done      = (state_q == RESP);
  assign wb_valid  = done && !we_q && !exc_q;
  assign exc_valid = done && exc_q;
  assign wb_rd     = rd_q;
  assign wb_data   = data_q;
  assign exc_cause = cause_q;

endmodule
